// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - replays one (A, B, OP) command as top_ALU button strobes and captures the LED result
module alu_cmd_sequencer #(
  parameter int NB_DATA = 6,
  parameter int NB_OP   = 6,
  parameter int SETTLE  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_sw,
  output logic [2:0]         o_buttons,
  input  logic [NB_DATA-1:0] i_led,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  input  logic               i_result_ready,
  output logic               o_busy
);

  // Counter only has to reach SETTLE-1; keep at least one bit so SETTLE of 0 or 1 still elaborates.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((SETTLE > 0) ? (SETTLE - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_LOAD_OP = 3'd3,
    S_WAIT    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [NB_DATA-1:0] a_reg;
  logic [NB_DATA-1:0] b_reg;
  logic [NB_OP-1:0]   op_reg;
  logic [NB_DATA-1:0] result_reg;
  logic [CW-1:0]      cnt;
  logic               capture;

  // State register, command latch, settle counter and result capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && i_cmd_valid) begin
        a_reg  <= i_a;
        b_reg  <= i_b;
        op_reg <= i_op;
      end
      if (state == S_LOAD_OP) begin
        cnt <= CNT_INIT;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        result_reg <= i_led;
      end
    end
  end

  // Next-state decode; capture fires on the edge that leaves the settle window.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      S_IDLE:    if (i_cmd_valid) state_nx = S_LOAD_A;
      S_LOAD_A:  state_nx = S_LOAD_B;
      S_LOAD_B:  state_nx = S_LOAD_OP;
      S_LOAD_OP: begin
        if (SETTLE == 0) begin
          state_nx = S_RESP;
          capture  = 1'b1;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_RESP;
          capture  = 1'b1;
        end
      end
      S_RESP:    if (i_result_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register and latched command only.
  always_comb begin
    o_sw      = '0;
    o_buttons = 3'b000;
    case (state)
      S_LOAD_A:  begin o_sw = a_reg; o_buttons = 3'b100; end
      S_LOAD_B:  begin o_sw = b_reg; o_buttons = 3'b010; end
      S_LOAD_OP: begin o_sw = NB_DATA'(op_reg); o_buttons = 3'b001; end
      S_WAIT:    o_sw = NB_DATA'(op_reg);
      S_RESP:    o_sw = NB_DATA'(op_reg);
      default:   o_sw = '0;
    endcase
  end

  assign o_cmd_ready    = (state == S_IDLE);
  assign o_busy         = (state != S_IDLE);
  assign o_result_valid = (state == S_RESP);
  assign o_result       = result_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer (SETTLE=2 and SETTLE=0 instances)
module tb_alu_cmd_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       result_ready = 1'b1;
  logic [5:0] cmd_a = '0;
  logic [5:0] cmd_b = '0;
  logic [5:0] cmd_op = '0;

  logic [5:0] sw [2];
  logic [5:0] res [2];
  logic [5:0] led [2];
  logic [2:0] btn [2];
  logic       rdy [2];
  logic       rv [2];
  logic       busy [2];

  int n_checks = 0;
  int n_fail = 0;
  bit started = 0;

  always #5 clock = ~clock;

  alu_cmd_sequencer #(.NB_DATA(6), .NB_OP(6), .SETTLE(2)) u_dut_s2 (
    .clock(clock), .reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy[0]),
    .i_a(cmd_a), .i_b(cmd_b), .i_op(cmd_op), .o_sw(sw[0]), .o_buttons(btn[0]),
    .i_led(led[0]), .o_result(res[0]), .o_result_valid(rv[0]),
    .i_result_ready(result_ready), .o_busy(busy[0])
  );

  alu_cmd_sequencer #(.NB_DATA(6), .NB_OP(6), .SETTLE(0)) u_dut_s0 (
    .clock(clock), .reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(rdy[1]),
    .i_a(cmd_a), .i_b(cmd_b), .i_op(cmd_op), .o_sw(sw[1]), .o_buttons(btn[1]),
    .i_led(led[1]), .o_result(res[1]), .o_result_valid(rv[1]),
    .i_result_ready(result_ready), .o_busy(busy[1])
  );

  function automatic int settle(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [5:0] alu(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
    logic signed [5:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      default: return 6'h00;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for top_ALU: operand registers loaded by the strobes, strobed value visible immediately.
  logic [5:0] ra [2] = '{6'd0, 6'd0};
  logic [5:0] rb [2] = '{6'd0, 6'd0};
  logic [5:0] rop [2] = '{6'd0, 6'd0};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      led[i] = alu(btn[i][2] ? sw[i] : ra[i], btn[i][1] ? sw[i] : rb[i], btn[i][0] ? sw[i] : rop[i]);
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (btn[i][2]) ra[i] <= sw[i];
      if (btn[i][1]) rb[i] <= sw[i];
      if (btn[i][0]) rop[i] <= sw[i];
    end
  end

  // Reference model: mt = cycles since accept (-1 idle); response phase starts at 4+SETTLE.
  int         mt [2] = '{-1, -1};
  logic [5:0] ma [2];
  logic [5:0] mb [2];
  logic [5:0] mop [2];
  logic [5:0] mres [2] = '{6'd0, 6'd0};

  always @(posedge clock) begin
    started = 1;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        mt[i] = -1;
        mres[i] = 6'd0;
      end else if (mt[i] < 0) begin
        if (cmd_valid) begin
          ma[i] = cmd_a; mb[i] = cmd_b; mop[i] = cmd_op; mt[i] = 1;
        end
      end else if (mt[i] >= 4 + settle(i)) begin
        if (result_ready) mt[i] = -1;
      end else begin
        if (mt[i] == 3 + settle(i)) mres[i] = alu(ma[i], mb[i], mop[i]);
        mt[i] = mt[i] + 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int t;
        int s;
        int exp_btn;
        int exp_sw;
        t = mt[i];
        s = settle(i);
        exp_btn = (t == 1) ? 4 : (t == 2) ? 2 : (t == 3) ? 1 : 0;
        exp_sw  = (t < 0) ? 0 : (t == 1) ? int'(ma[i]) : (t == 2) ? int'(mb[i]) : int'(mop[i]);
        chk($sformatf("cmd_ready[%0d]", i), int'(rdy[i]), int'(t < 0));
        chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(t >= 0));
        chk($sformatf("result_valid[%0d]", i), int'(rv[i]), int'(t >= 4 + s));
        chk($sformatf("buttons[%0d]", i), int'(btn[i]), exp_btn);
        chk($sformatf("onehot0[%0d]", i), int'($onehot0(btn[i])), 1);
        chk($sformatf("result[%0d]", i), int'(res[i]), int'(mres[i]));
        if (t < 4 + s) chk($sformatf("sw[%0d]", i), int'(sw[i]), exp_sw);
      end
    end
  end

  // Issue one command with ready held high; check result literal and accept-to-valid latency.
  task automatic run_directed(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op,
                              input logic [5:0] exp);
    int seen [2];
    seen = '{-1, -1};
    @(negedge clock);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; result_ready = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 1) begin
        cmd_valid = 1'b0; cmd_a = 6'($urandom); cmd_b = 6'($urandom); cmd_op = 6'($urandom);
      end
      for (int i = 0; i < 2; i++) begin
        if (seen[i] < 0 && rv[i]) begin
          seen[i] = n;
          chk($sformatf("directed_result[%0d]", i), int'(res[i]), int'(exp));
        end
      end
    end
    chk("latency_settle2", seen[0], 6);
    chk("latency_settle0", seen[1], 4);
  endtask

  logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  initial begin
    chk("model_add", int'(alu(6'd3, 6'd5, 6'h20)), 8);
    chk("model_sub", int'(alu(6'd7, 6'd2, 6'h22)), 5);
    chk("model_and", int'(alu(6'd3, 6'd3, 6'h24)), 3);
    chk("model_or", int'(alu(6'd2, 6'd9, 6'h25)), 11);

    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", int'(rdy[i]), 1);
      chk("reset_buttons", int'(btn[i]), 0);
      chk("reset_result", int'(res[i]), 0);
      chk("reset_sw", int'(sw[i]), 0);
    end
    reset = 1'b1;

    run_directed(6'd3, 6'd5, 6'h20, 6'd8);
    run_directed(6'd7, 6'd2, 6'h22, 6'd5);
    run_directed(6'd3, 6'd3, 6'h24, 6'd3);
    run_directed(6'd1, 6'd1, 6'h20, 6'd2);

    // Backpressure: result held while ready is low, further valid commands refused.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_a = 6'd2; cmd_b = 6'd9; cmd_op = 6'h25; result_ready = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      cmd_a = 6'($urandom); cmd_b = 6'($urandom); cmd_op = ops[$urandom_range(7)];
    end
    for (int i = 0; i < 2; i++) begin
      chk("bp_valid", int'(rv[i]), 1);
      chk("bp_ready", int'(rdy[i]), 0);
      chk("bp_result", int'(res[i]), 11);
    end
    cmd_valid = 1'b0; result_ready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("bp_release_ready", int'(rdy[i]), 1);
      chk("bp_release_valid", int'(rv[i]), 0);
    end

    // Reset while LOAD_B is on the wires: no OP strobe may follow.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_a = 6'd4; cmd_b = 6'd6; cmd_op = 6'h20;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) chk("pre_reset_btn_b", int'(btn[i]), 2);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("abort_buttons", int'(btn[i]), 0);
      chk("abort_sw", int'(sw[i]), 0);
      chk("abort_busy", int'(busy[i]), 0);
      chk("abort_ready", int'(rdy[i]), 1);
    end
    repeat (4) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) chk("abort_no_op_strobe", int'(btn[i]), 0);
    end

    // Randomized traffic with occasional reset and backpressure.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      cmd_valid    = ($urandom_range(2) != 0);
      cmd_a        = 6'($urandom);
      cmd_b        = 6'($urandom);
      cmd_op       = ops[$urandom_range(7)];
      result_ready = ($urandom_range(3) != 0);
      reset        = ($urandom_range(199) != 0);
    end
    @(negedge clock);
    reset = 1'b1; cmd_valid = 1'b0; result_ready = 1'b1;
    repeat (12) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
